prog_loader: RTL and testbench
==============================

# prog_loader

Program loader: the write-side counterpart of the processor's instruction fetch path. Accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them sequentially into the 128×16 instruction RAM starting at address 0. Holds the processor (`cpu_hold`) while loading. Reports completion and checksum status.

## Interface
- No parameters. Widths are fixed by the shared package: address 7 bits, word 16 bits.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle request to begin a load. Sampled only in IDLE.
- `din` in 8: stream byte.
- `din_valid` in 1: `din` is valid.
- `din_ready` out 1: loader can accept a byte. Transfer occurs when `din_valid & din_ready`.
- `mem_wr` out 1: RAM write strobe, one cycle per word.
- `mem_addr` out 7: RAM write address.
- `mem_din` out 16: RAM write data.
- `cpu_hold` out 1: keeps the processor in reset while a load is in progress.
- `busy` out 1: loader not in IDLE.
- `done` out 1: one-cycle pulse at load end.
- `err` out 1: checksum mismatch. Sticky until the next accepted `start` or `reset`.

## Operation
- Stream format:
  - LEN byte: word count N, where 0 means 128.
  - N word pairs, each sent high byte then low byte.
  - CSUM byte: XOR of LEN and all data bytes.
- FSM states and transitions:
  - IDLE: on `start`, go to LEN. Clear `err`, `mem_addr`, and the XOR accumulator.
  - LEN: on transfer, latch N and go to HI.
  - HI: on transfer, latch the high byte and go to LO.
  - LO: on transfer, latch the low byte and go to WR.
  - WR: assert `mem_wr` for exactly one cycle with the assembled word on `mem_din` and the current `mem_addr`. Then increment the address and the words-written count. If count equals N, go to CSUM; otherwise go to HI.
  - CSUM: on transfer, compare the byte with the accumulator and set `err` on mismatch. Go to DONE.
  - DONE: `done` = 1 for one cycle, then return to IDLE.
- `din_ready` = 1 only in LEN, HI, LO, and CSUM. It is 0 in WR, so there is one bubble per word.
- The XOR accumulator updates on every transfer in LEN, HI, and LO.
- `busy` = `cpu_hold` = (state ≠ IDLE).
- `start` outside IDLE is ignored.
- `mem_addr` holds its last value in IDLE. It wraps 127 → 0 only on a 128-word load, and the wrap is never written.
- All outputs are registered.

## Timing
- Reset values: state = IDLE; `din_ready` = `mem_wr` = `cpu_hold` = `busy` = `done` = `err` = 0; `mem_addr` = 0; `mem_din` = 0.
- `reset` asserted mid-load returns to IDLE at that edge and drops `mem_wr` and `cpu_hold` the same edge. Words already written stay in RAM.
- `start` at edge t: `busy`, `cpu_hold`, and `din_ready` are 1 from t+1.
- A low-byte transfer at edge t: `mem_wr` is high during the cycle t+1 → t+2. `din_ready` returns at t+2.
- Minimum load time with `din_valid` held high: 2 + 3N + 2 cycles from `start` to the `done` pulse.
- `din_valid` low stalls the current state indefinitely. No timeout.
- `err` becomes valid in the same cycle as the `done` pulse.

## Structure
- `prog_loader_pkg`:
  - `ADDR_W` = 7, `WORD_W` = 16, `BYTE_W` = 8.
  - State enum: IDLE, LEN, HI, LO, WR, CSUM, DONE.
  - `MAX_WORDS` = 128.
- Single module with no sub-module. The FSM, byte assembler, address/word counter, and XOR accumulator are all inline.
- The top level wires `mem_wr`, `mem_addr`, and `mem_din` into the RAM's write port. It muxes the RAM address: `mem_addr` while `busy`, the processor's fetch address otherwise. The processor's reset is driven by `reset | cpu_hold`.

## Test plan
- **Nominal 2-word load.** `start`, then bytes 0x02, 0x00, 0x40, 0x02, 0x81, 0xC1 with `din_valid` held high → `mem_wr` at address 0 with data 0x0040, then address 1 with data 0x0281. `done` pulses at cycle 10 after `start`. `err` = 0.
- **Bad checksum.** Same stream with last byte 0x00 → both words written, `done` pulses, `err` = 1. `err` clears on the next `start`.
- **Full 128-word load (LEN = 0x00).** Word k = k → 128 writes at addresses 0..127. `mem_addr` ends at 0. Correct CSUM gives `err` = 0.
- **Stalls.** `din_valid` deasserted for 5 cycles between the high and low bytes of word 1 → no `mem_wr` during the stall. Final RAM contents match the nominal case.
- **Reset mid-load.** `reset` pulsed after the high byte of word 1 → next cycle all outputs at reset values and state IDLE. A new load then writes from address 0.
- **`start` while busy.** `start` pulsed in the HI state → ignored. Stream completes normally with a single `done` pulse.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared widths, state encoding and helpers for the program loader.
package prog_loader_pkg;

    localparam int ADDR_W    = 7;
    localparam int WORD_W    = 16;
    localparam int BYTE_W    = 8;
    localparam int MAX_WORDS = 128;

    // Word counter must be able to hold MAX_WORDS itself (128), so one bit wider than the address.
    localparam int CNT_W     = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        HI,
        LO,
        WR,
        CSUM,
        DONE
    } state_e;

    // A LEN byte of zero stands for a full RAM image.
    function automatic logic [CNT_W-1:0] len_to_words(input logic [BYTE_W-1:0] len_byte);
        if (len_byte == '0) begin
            return CNT_W'(MAX_WORDS);
        end
        return CNT_W'(len_byte);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Program loader: turns a LEN / word-pair / CSUM byte stream into sequential
// 16-bit writes into the instruction RAM, holding the CPU while it runs.
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BYTE_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_din,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BYTE_W-1:0]  hi_q, hi_d;
    logic [BYTE_W-1:0]  acc_q, acc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               err_q, err_d;
    logic               din_ready_q, din_ready_d;
    logic               mem_wr_q, mem_wr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               xfer;

    // A byte moves only when the registered ready and the source valid coincide.
    assign xfer = din_valid & din_ready_q;

    // Next-state, datapath updates and the look-ahead values of the registered outputs.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        acc_d   = acc_q;
        addr_d  = addr_q;
        word_d  = word_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LEN;
                    err_d   = 1'b0;
                    addr_d  = '0;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            LEN: begin
                if (xfer) begin
                    len_d   = len_to_words(din);
                    acc_d   = acc_q ^ din;
                    state_d = HI;
                end
            end
            HI: begin
                if (xfer) begin
                    hi_d    = din;
                    acc_d   = acc_q ^ din;
                    state_d = LO;
                end
            end
            LO: begin
                if (xfer) begin
                    word_d  = {hi_q, din};
                    acc_d   = acc_q ^ din;
                    state_d = WR;
                end
            end
            WR: begin
                // The write itself is the registered strobe; here we step past it.
                // On a 128-word load the address wraps to 0 but is never written.
                addr_d = addr_q + ADDR_W'(1);
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_d == len_q) begin
                    state_d = CSUM;
                end else begin
                    state_d = HI;
                end
            end
            CSUM: begin
                if (xfer) begin
                    if (din != acc_q) begin
                        err_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they appear registered with it.
        din_ready_d = (state_d == LEN) || (state_d == HI) ||
                      (state_d == LO)  || (state_d == CSUM);
        mem_wr_d    = (state_d == WR);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    // State and datapath registers; reset aborts any load in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            hi_q        <= '0;
            acc_q       <= '0;
            addr_q      <= '0;
            word_q      <= '0;
            err_q       <= 1'b0;
            din_ready_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            acc_q       <= acc_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            err_q       <= err_d;
            din_ready_q <= din_ready_d;
            mem_wr_q    <= mem_wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign din_ready = din_ready_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = addr_q;
    assign mem_din   = word_q;
    assign cpu_hold  = busy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of whole loads plus hand-written
// stall, reset-abort and start-while-busy sequences; RAM writes are scoreboarded.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic        mem_wr;
    logic [6:0]  mem_addr;
    logic [15:0] mem_din;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        string      name;
        logic [7:0] len;
        int         pat;
        bit         corrupt;
        bit         exp_err;
        logic [6:0] exp_addr;
    } vec_t;

    wr_t         exp_q[$];
    vec_t        tbl[6];
    logic [15:0] ram[128];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;
    int          wr_cnt = 0;
    logic        err_at_done = 1'b0;
    int          addr_exp = 0;
    logic [7:0]  csum = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop the scoreboard on every RAM write, note done pulses.
    always @(negedge clk) begin
        wr_t e;
        if (mem_wr) begin
            wr_cnt++;
            ram[mem_addr] = mem_din;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", mem_addr, mem_din);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_din !== e.data) begin
                    fails++;
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             mem_addr, mem_din, e.addr, e.data);
                end else begin
                    $display("[TB] write addr=%0d data=%h", mem_addr, mem_din);
                end
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc    = cyc;
            err_at_done = err;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input int pat, input int k);
        case (pat)
            0:       return 16'(k);
            1:       return (k == 0) ? 16'h0040 : 16'h0281;
            default: return 16'(k * 16'h1357) ^ 16'hA5A5;
        endcase
    endfunction

    // Present a byte and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard     = 0;
        din       = b;
        din_valid = 1'b1;
        while (din_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got din_ready=%b, required 1 within 100 cycles", din_ready);
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] b);
        csum = csum ^ b;
        send_byte(b);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_data(w[15:8]);
        exp_q.push_back({7'(addr_exp), w});
        addr_exp++;
        send_data(w[7:0]);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
        addr_exp  = 0;
        csum      = 8'h00;
        check("busy_after_start", 32'(busy), 32'd1);
        check("cpu_hold_after_start", 32'(cpu_hold), 32'd1);
        check("din_ready_after_start", 32'(din_ready), 32'd1);
        check("err_cleared_by_start", 32'(err), 32'd0);
    endtask

    // Send the checksum, wait (bounded) for done and check the end-of-load state.
    task automatic finish_load(input string name, input int d0, input int w0, input int n,
                               input bit corrupt, input bit exp_err, input logic [6:0] exp_addr);
        int guard;
        send_byte(corrupt ? (csum ^ 8'h5A) : csum);
        guard = 0;
        while (done_cnt == d0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_err_at_done"}, 32'(err_at_done), 32'(exp_err));
        check({name, "_err_sticky"}, 32'(err), 32'(exp_err));
        check({name, "_end_addr"}, 32'(mem_addr), 32'(exp_addr));
        check({name, "_busy_idle"}, 32'(busy), 32'd0);
        check({name, "_write_count"}, 32'(wr_cnt - w0), 32'(n));
        check({name, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
        $display("[TB] load %s: words=%0d err=%b end_addr=%0d", name, n, err, mem_addr);
    endtask

    task automatic run_load(input vec_t v);
        int d0, w0, n;
        d0 = done_cnt;
        w0 = wr_cnt;
        n  = (v.len == 8'h00) ? 128 : int'(v.len);
        do_start();
        send_data(v.len);
        for (int k = 0; k < n; k++) send_word(word_of(v.pat, k));
        finish_load(v.name, d0, w0, n, v.corrupt, v.exp_err, v.exp_addr);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0;
        tbl[0] = '{"nominal",   8'h02, 1, 1'b0, 1'b0, 7'd2};
        tbl[1] = '{"bad_csum",  8'h02, 1, 1'b1, 1'b1, 7'd2};
        tbl[2] = '{"full_128",  8'h00, 0, 1'b0, 1'b0, 7'd0};
        tbl[3] = '{"one_word",  8'h01, 2, 1'b0, 1'b0, 7'd1};
        tbl[4] = '{"five_bad",  8'h05, 2, 1'b1, 1'b1, 7'd5};
        tbl[5] = '{"three_ok",  8'h03, 2, 1'b0, 1'b0, 7'd3};

        reset = 1'b1; start = 1'b0; din = 8'h00; din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_din_ready", 32'(din_ready), 32'd0);
        check("rst_mem_wr",    32'(mem_wr),    32'd0);
        check("rst_cpu_hold",  32'(cpu_hold),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_mem_din",   32'(mem_din),   32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_load(tbl[i]);
            // Nominal load: counting the start cycle as cycle 1, done is in cycle 10.
            if (i == 0) check("nominal_done_latency", 32'(done_cyc - start_cyc + 2), 32'd10);
        end

        // Stall for 5 cycles between the high and low bytes of word 1.
        d0 = done_cnt; w0 = wr_cnt;
        ram[0] = 16'h0000; ram[1] = 16'h0000;
        do_start();
        send_data(8'h02);
        send_word(16'h0040);
        send_data(8'h02);
        exp_q.push_back({7'(addr_exp), 16'h0281});
        addr_exp++;
        begin
            int w_stall;
            w_stall = wr_cnt;
            repeat (5) @(posedge clk);
            #1;
            check("stall_no_write", 32'(wr_cnt - w_stall), 32'd0);
            check("stall_still_ready", 32'(din_ready), 32'd1);
        end
        send_data(8'h81);
        finish_load("stall", d0, w0, 2, 1'b0, 1'b0, 7'd2);
        check("stall_ram0", 32'(ram[0]), 32'h0040);
        check("stall_ram1", 32'(ram[1]), 32'h0281);

        // Reset after the high byte of word 1: everything returns to reset values.
        do_start();
        send_data(8'h02);
        send_word(16'h1234);
        send_data(8'h56);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_din_ready", 32'(din_ready), 32'd0);
        check("midrst_mem_wr",    32'(mem_wr),    32'd0);
        check("midrst_cpu_hold",  32'(cpu_hold),  32'd0);
        check("midrst_busy",      32'(busy),      32'd0);
        check("midrst_done",      32'(done),      32'd0);
        check("midrst_mem_addr",  32'(mem_addr),  32'd0);
        check("midrst_mem_din",   32'(mem_din),   32'd0);
        check("midrst_ram_kept",  32'(ram[0]),    32'h1234);
        reset = 1'b0;
        @(posedge clk); #1;
        run_load(tbl[0]);

        // start pulsed while in HI must be ignored.
        d0 = done_cnt; w0 = wr_cnt;
        do_start();
        send_data(8'h02);
        start = 1'b1;
        send_data(8'h00);
        start = 1'b0;
        exp_q.push_back({7'(addr_exp), 16'h0040});
        addr_exp++;
        send_data(8'h40);
        send_word(16'h0281);
        finish_load("start_busy", d0, w0, 2, 1'b0, 1'b0, 7'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
